// File: rtl/nested_mux_pkg.sv
// nested_mux_pkg: shared constants and types for the nested_mux steering stage.
// Holds the default data width and the 2-bit source-code encoding.
package nested_mux_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        SRC_A = 2'd0,
        SRC_B = 2'd1,
        SRC_D = 2'd2,
        SRC_E = 2'd3
    } src_t;

endpackage

// File: rtl/nested_mux_if.sv
// nested_mux_if: bundle of data sources, selects and registered outputs.
// master drives a/b/d/e/sel1..3 and reads c/f; slave (the mux) does the reverse.
// With NESTED_MUX_SRC_EN defined, c_src/f_src carry the chosen source codes.
interface nested_mux_if
    import nested_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic             sel1;
    logic             sel2;
    logic             sel3;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] f;
`ifdef NESTED_MUX_SRC_EN
    src_t             c_src;
    src_t             f_src;
`endif

`ifdef NESTED_MUX_SRC_EN
    modport master (
        output a, b, d, e, sel1, sel2, sel3,
        input  c, f, c_src, f_src
    );

    modport slave (
        input  a, b, d, e, sel1, sel2, sel3,
        output c, f, c_src, f_src
    );
`else
    modport master (
        output a, b, d, e, sel1, sel2, sel3,
        input  c, f
    );

    modport slave (
        input  a, b, d, e, sel1, sel2, sel3,
        output c, f
    );
`endif

endinterface

// File: rtl/nested_mux_path.sv
// nested_mux_path: combinational 3-tier priority mux (hi > mid > d > e).
// Ports: hi, mid, d, e data in; sel1..sel3 tier selects; data out.
// With NESTED_MUX_SRC_EN, also reports the chosen source code on src;
// HI_SRC/MID_SRC say which source is wired to hi and mid.
module nested_mux_path
    import nested_mux_pkg::*;
#(
    parameter int   WIDTH   = DEF_WIDTH
`ifdef NESTED_MUX_SRC_EN
    ,
    parameter src_t HI_SRC  = SRC_A,
    parameter src_t MID_SRC = SRC_B
`endif
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] mid,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
`ifdef NESTED_MUX_SRC_EN
    output src_t             src,
`endif
    output logic [WIDTH-1:0] data
);

    always_comb begin
        data = e;
`ifdef NESTED_MUX_SRC_EN
        src  = SRC_E;
`endif
        if (sel1) begin
            data = hi;
`ifdef NESTED_MUX_SRC_EN
            src  = HI_SRC;
`endif
        end else if (sel2) begin
            data = mid;
`ifdef NESTED_MUX_SRC_EN
            src  = MID_SRC;
`endif
        end else if (sel3) begin
            data = d;
`ifdef NESTED_MUX_SRC_EN
            src  = SRC_D;
`endif
        end
    end

endmodule

// File: rtl/nested_mux.sv
// nested_mux: registered nested priority mux, one cycle latency.
// Ports: clk, rst (sync, active-high) plus bus (nested_mux_if.slave):
// c favours a then b, f favours b then a; both fall back to d, then e.
// Optional macro NESTED_MUX_SRC_EN adds registered c_src/f_src codes
// (reset value SRC_E).
module nested_mux
    import nested_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    nested_mux_if.slave  bus
);

    logic [WIDTH-1:0] c_nxt;
    logic [WIDTH-1:0] f_nxt;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] f_q;

`ifdef NESTED_MUX_SRC_EN
    src_t c_src_nxt;
    src_t f_src_nxt;
    src_t c_src_q;
    src_t f_src_q;
`endif

    nested_mux_path #(
        .WIDTH   (WIDTH)
`ifdef NESTED_MUX_SRC_EN
        ,
        .HI_SRC  (SRC_A),
        .MID_SRC (SRC_B)
`endif
    ) u_c_path (
        .hi   (bus.a),
        .mid  (bus.b),
        .d    (bus.d),
        .e    (bus.e),
        .sel1 (bus.sel1),
        .sel2 (bus.sel2),
        .sel3 (bus.sel3),
`ifdef NESTED_MUX_SRC_EN
        .src  (c_src_nxt),
`endif
        .data (c_nxt)
    );

    // Same chain with a and b swapped in the top two tiers.
    nested_mux_path #(
        .WIDTH   (WIDTH)
`ifdef NESTED_MUX_SRC_EN
        ,
        .HI_SRC  (SRC_B),
        .MID_SRC (SRC_A)
`endif
    ) u_f_path (
        .hi   (bus.b),
        .mid  (bus.a),
        .d    (bus.d),
        .e    (bus.e),
        .sel1 (bus.sel1),
        .sel2 (bus.sel2),
        .sel3 (bus.sel3),
`ifdef NESTED_MUX_SRC_EN
        .src  (f_src_nxt),
`endif
        .data (f_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            f_q <= '0;
        end else begin
            c_q <= c_nxt;
            f_q <= f_nxt;
        end
    end

`ifdef NESTED_MUX_SRC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            c_src_q <= SRC_E;
            f_src_q <= SRC_E;
        end else begin
            c_src_q <= c_src_nxt;
            f_src_q <= f_src_nxt;
        end
    end

    assign bus.c_src = c_src_q;
    assign bus.f_src = f_src_q;
`endif

    assign bus.c = c_q;
    assign bus.f = f_q;

endmodule

// File: tb/tb_nested_mux.sv
// tb_nested_mux: directed vectors with a queue-based scoreboard.
// The stimulus pushes hand-computed results; a negedge monitor pops and compares.
module tb_nested_mux;
    import nested_mux_pkg::*;

    typedef struct {
        string      name;
        logic [3:0] c;
        logic [3:0] f;
        src_t       cs;
        src_t       fs;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    nested_mux_if #(.WIDTH(4)) bus ();

    nested_mux #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk4(input string nm, input logic [3:0] act,
                        input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    // Monitor: the output is valid every cycle, so one entry per negedge.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk4({x.name, ".c"}, bus.c, x.c);
            chk4({x.name, ".f"}, bus.f, x.f);
`ifdef NESTED_MUX_SRC_EN
            chk4({x.name, ".c_src"}, {2'b00, bus.c_src}, {2'b00, x.cs});
            chk4({x.name, ".f_src"}, {2'b00, bus.f_src}, {2'b00, x.fs});
`endif
        end
    end

    task automatic apply(
        input string      nm,
        input logic       r,
        input logic [2:0] s,
        input logic [3:0] va, vb, vd, ve,
        input logic [3:0] ec, ef,
        input src_t       ecs, efs
    );
        exp_t x;
        rst      = r;
        bus.sel1 = s[2];
        bus.sel2 = s[1];
        bus.sel3 = s[0];
        bus.a    = va;
        bus.b    = vb;
        bus.d    = vd;
        bus.e    = ve;
        x.name = nm;
        x.c    = ec;
        x.f    = ef;
        x.cs   = ecs;
        x.fs   = efs;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        //    name     rst sel     a      b      d      e      c      f      c_src  f_src
        apply("rst0",  1, 3'b111, 4'hF, 4'hA, 4'h7, 4'h9, 4'h0, 4'h0, SRC_E, SRC_E);
        apply("rst1",  1, 3'b000, 4'h5, 4'h6, 4'h1, 4'h2, 4'h0, 4'h0, SRC_E, SRC_E);
        apply("dflt",  0, 3'b000, 4'h8, 4'h4, 4'hA, 4'h3, 4'h3, 4'h3, SRC_E, SRC_E);
        apply("tier3", 0, 3'b001, 4'h8, 4'h4, 4'h5, 4'h3, 4'h5, 4'h5, SRC_D, SRC_D);
        apply("t1_101",0, 3'b101, 4'hC, 4'h9, 4'h5, 4'h3, 4'hC, 4'h9, SRC_A, SRC_B);
        apply("t1_111",0, 3'b111, 4'hC, 4'h9, 4'h5, 4'h3, 4'hC, 4'h9, SRC_A, SRC_B);
        apply("t2_011",0, 3'b011, 4'hC, 4'h9, 4'h5, 4'h3, 4'h9, 4'hC, SRC_B, SRC_A);
        apply("t2_010",0, 3'b010, 4'h6, 4'h1, 4'hF, 4'h0, 4'h1, 4'h6, SRC_B, SRC_A);
        apply("t1_100",0, 3'b100, 4'h6, 4'h1, 4'hF, 4'h0, 4'h6, 4'h1, SRC_A, SRC_B);
        apply("t1_110",0, 3'b110, 4'h2, 4'hD, 4'hF, 4'h0, 4'h2, 4'hD, SRC_A, SRC_B);
        apply("midrst",1, 3'b011, 4'hC, 4'h9, 4'h5, 4'h3, 4'h0, 4'h0, SRC_E, SRC_E);
        apply("rel",   0, 3'b011, 4'hC, 4'h9, 4'h5, 4'h3, 4'h9, 4'hC, SRC_B, SRC_A);
        apply("e_ones",0, 3'b000, 4'h1, 4'h2, 4'h4, 4'hF, 4'hF, 4'hF, SRC_E, SRC_E);
        apply("d_zero",0, 3'b001, 4'h1, 4'h2, 4'h0, 4'hF, 4'h0, 4'h0, SRC_D, SRC_D);
        apply("a_ones",0, 3'b100, 4'hF, 4'h0, 4'h7, 4'h8, 4'hF, 4'h0, SRC_A, SRC_B);

        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
